// File: rtl/monitor_comparador.sv
// monitor_comparador: windowed match counter with a sticky alarm for consecutive matches
module monitor_comparador #(
  parameter int WINDOW = 16,
  parameter int PERSIST = 3,
  localparam int CW = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          Q,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          count_valid,
  output logic [CW-1:0] run_len,
  output logic          alarm,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] idx_q, idx_d, acc_q, acc_d, count_q, count_d, run_q, run_d;
  logic alarm_q, alarm_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    acc_d = acc_q;
    count_d = count_q;
    run_d = run_q;
    alarm_d = alarm_q;
    if (clear) begin
      state_d = IDLE;
      idx_d = '0;
      acc_d = '0;
      run_d = '0;
      alarm_d = 1'b0;
    end else if (en) begin
      run_d = !Q ? '0 : run_q == CW'(PERSIST) ? run_q : run_q + 1'b1;
      alarm_d = alarm_q | (run_d == CW'(PERSIST));
      if (state_q == ACCUM && idx_q == CW'(WINDOW - 1)) begin
        state_d = REPORT;
        count_d = acc_q + CW'(Q);
        idx_d = '0;
        acc_d = '0;
      end else if (state_q == ACCUM) begin
        idx_d = idx_q + 1'b1;
        acc_d = acc_q + CW'(Q);
      end else begin
        // a strobe in IDLE or REPORT opens a fresh window with this sample
        state_d = ACCUM;
        idx_d = CW'(1);
        acc_d = CW'(Q);
      end
    end else if (state_q == REPORT) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      acc_q <= '0;
      count_q <= '0;
      run_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      count_q <= count_d;
      run_q <= run_d;
      alarm_q <= alarm_d;
    end
  end
  assign count = count_q;
  assign count_valid = state_q == REPORT;
  assign run_len = run_q;
  assign alarm = alarm_q;
  assign busy = state_q == ACCUM;
endmodule
